// File: rtl/ntt_bitrev_stream_reorder.sv
// Streaming bit-reverse reorder buffer: natural-order frames in, bit-reversed frames out.
// Latency: out_valid rises the cycle after the last (N-1th) input of a frame is accepted.
// Backpressure: ping-pong banks absorb up to 2N samples; in_ready drops while the write bank is full.
//
// Ports:
//   clk, rst              : single clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_data carries natural-order coefficients
//   out_valid/out_ready   : output handshake, out_data carries bit-reversed-order coefficients
//   out_last              : marks the final sample of each output frame
module ntt_bitrev_stream_reorder #(
    parameter int DATA_W = 8,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST_IDX = '1;

    // Two coefficient banks; contents are deliberately left unreset.
    logic [DATA_W-1:0] r_mem [2][N];

    logic [1:0]       r_full;
    logic             r_wbank;
    logic             r_rbank;
    logic [LOG_N-1:0] r_wcnt;
    logic [LOG_N-1:0] r_rcnt;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_wr_wrap;
    logic             w_rd_wrap;
    logic [LOG_N-1:0] w_rd_addr;

    // Read address is the read counter with its bits mirrored.
    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < LOG_N; i++) begin
            w_rd_addr[i] = r_rcnt[LOG_N-1-i];
        end
    end

    // All outputs depend on registered state only.
    assign in_ready  = !r_full[r_wbank];
    assign out_valid = r_full[r_rbank];
    assign out_data  = out_valid ? r_mem[r_rbank][w_rd_addr] : '0;
    assign out_last  = out_valid && (r_rcnt == LAST_IDX);

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_wr_wrap  = w_in_xfer && (r_wcnt == LAST_IDX);
    assign w_rd_wrap  = w_out_xfer && (r_rcnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_mem[r_wbank][r_wcnt] <= in_data;
        end
    end

    // Write and read sides always own different banks' flag transitions,
    // so a set on one bank and a clear on the other can land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 2'b00;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            if (w_in_xfer) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_wr_wrap) begin
                r_full[r_wbank] <= 1'b1;
                r_wbank         <= ~r_wbank;
            end
            if (w_out_xfer) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
            if (w_rd_wrap) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= ~r_rbank;
            end
        end
    end

endmodule
